// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions: transfer/size/response codes, responder FSM states, byte-lane helpers.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

  // Little-endian lane mask; low address bits below the size alignment are ignored
  // and any code above word is treated as a word.
  function automatic logic [3:0] size_to_strb(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
    logic mis;
    case (size)
      HSIZE_HALF: mis = addr[0];
      HSIZE_WORD: mis = |addr;
      default:    mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ahb_sram_byte_mem.sv
// Word-organised SRAM array with per-byte write enables and an asynchronous read port.
module ahb_sram_byte_mem
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [3:0][7:0] mem [2**ADDR_W];

  // NOTE: the array has no reset branch; clearing it would turn the RAM into flops.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][b] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states.
// Optional ERROR responses (range/size/alignment) are built when AHB_SRAM_ERR_EN is defined.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int MEM_ADDR_W  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         WORD_W    = MEM_ADDR_W - 2;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  htrans_e          trans;
  logic             accept;
  logic             req_err;
  logic             dp_valid;
  logic             dp_write;
  logic [3:0]       dp_strb;
  logic [WORD_W-1:0] dp_word;
  ahb_state_e       state;
  logic [2:0]       wait_cnt;
  logic             ready_q;
  logic             resp_q;
  logic [3:0]       mem_be;
  logic [31:0]      mem_rdata;
  logic             unused_ctrl;

  assign trans  = htrans_e'(HTRANS);
  assign accept = HSEL && HREADY && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

`ifdef AHB_SRAM_ERR_EN
  assign req_err = (|HADDR[31:MEM_ADDR_W]) || (HSIZE > HSIZE_WORD) ||
                   is_misaligned(HSIZE, HADDR[1:0]);
  assign HRESP   = resp_q;
  assign unused_ctrl = ^{HBURST, HPROT, HMASTLOCK};
`else
  // Upper address bits are dropped, so the window aliases across the whole map.
  assign req_err = 1'b0;
  assign HRESP   = HRESP_OKAY;
  assign unused_ctrl = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:MEM_ADDR_W], resp_q};
`endif

  // Address-phase capture; errored transfers never open a data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_strb  <= '0;
      dp_word  <= '0;
    end else if (HREADY) begin
      dp_valid <= accept && !req_err;
      if (accept) begin
        dp_write <= HWRITE;
        dp_strb  <= size_to_strb(HSIZE, HADDR[1:0]);
        dp_word  <= HADDR[MEM_ADDR_W-1:2];
      end
    end
  end

  // NOTE: state and outputs are registered with non-blocking assignments so every
  // branch sees the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      ready_q  <= 1'b1;
      resp_q   <= HRESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 3'd1) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
`ifdef AHB_SRAM_ERR_EN
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
        end
`endif
        default: begin
          // IDLE and ERR2 both have HREADY high and take a new address phase.
          if (accept && req_err) begin
            state   <= ST_ERR1;
            ready_q <= 1'b0;
            resp_q  <= HRESP_ERROR;
          end else if (accept && WAIT_STATES > 0) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_INIT;
            ready_q  <= 1'b0;
            resp_q   <= HRESP_OKAY;
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Commit only on the completing edge, so a read issued right behind sees the new word.
  assign mem_be = (dp_valid && dp_write && ready_q) ? dp_strb : 4'b0000;

  ahb_sram_byte_mem #(
    .ADDR_W (WORD_W)
  ) u_mem (
    .clk   (HCLK),
    .be    (mem_be),
    .addr  (dp_word),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HREADYOUT = ready_q;
  assign HRDATA    = (dp_valid && !dp_write) ? mem_rdata : 32'h0;

endmodule
